// File: rtl/dsp_vector_source.sv
// Table-driven stimulus/response engine: issues stored stimulus words, checks results, keeps pass/fail stats.
// Optional: define DSP_VECTOR_SOURCE_STOP_ON_FAIL_EN to end a run at the first failing vector.
`timescale 1ns/1ps
module dsp_vector_source #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_stim,
  input  logic [DATA_WIDTH-1:0] ld_exp,
  input  logic [ADDR_WIDTH:0]   num_tests,
  input  logic                  start,
  output logic                  stim_valid,
  input  logic                  stim_ready,
  output logic [DATA_WIDTH-1:0] stim_data,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  test_passed,
  output logic                  test_failed,
  output logic [ADDR_WIDTH:0]   test_count,
  output logic [ADDR_WIDTH:0]   fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_idx,
  output logic [DATA_WIDTH-1:0] first_fail_exp,
  output logic [DATA_WIDTH-1:0] first_fail_meas
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]         TO_ONE   = TW'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(0);

`ifdef DSP_VECTOR_SOURCE_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES,
    S_CHECK,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   ntests_q, ntests_d;
  logic [ADDR_WIDTH:0]   tcnt_q, tcnt_d;
  logic [ADDR_WIDTH:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]         tocnt_q, tocnt_d;
  logic [DATA_WIDTH-1:0] meas_q, meas_d;
  logic                  tmo_q, tmo_d;
  logic                  svalid_q, svalid_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  done_q, done_d;
  logic                  passed_q, passed_d;
  logic                  failed_q, failed_d;
  logic [ADDR_WIDTH-1:0] ffidx_q, ffidx_d;
  logic [DATA_WIDTH-1:0] ffexp_q, ffexp_d;
  logic [DATA_WIDTH-1:0] ffmeas_q, ffmeas_d;

  logic [DATA_WIDTH-1:0] stim_mem [DEPTH];
  logic [DATA_WIDTH-1:0] exp_mem  [DEPTH];

  logic vec_fail;
  logic last_vec;

  // Table has no reset; it is only writable while the engine is idle.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q == S_IDLE)) begin
      stim_mem[ld_addr] <= ld_stim;
      exp_mem[ld_addr]  <= ld_exp;
    end
  end

  assign vec_fail = tmo_q | (meas_q != exp_mem[idx_q]);
  assign last_vec = ((tcnt_q + CNT_ONE) == ntests_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ntests_d = ntests_q;
    tcnt_d   = tcnt_q;
    fcnt_d   = fcnt_q;
    tocnt_d  = tocnt_q;
    meas_d   = meas_q;
    tmo_d    = tmo_q;
    svalid_d = svalid_q;
    sdata_d  = sdata_q;
    done_d   = done_q;
    passed_d = passed_q;
    failed_d = failed_q;
    ffidx_d  = ffidx_q;
    ffexp_d  = ffexp_q;
    ffmeas_d = ffmeas_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ntests_d = num_tests;
          idx_d    = IDX_ZERO;
          tcnt_d   = '0;
          fcnt_d   = '0;
          tocnt_d  = '0;
          meas_d   = '0;
          tmo_d    = 1'b0;
          done_d   = 1'b0;
          passed_d = 1'b0;
          failed_d = 1'b0;
          ffidx_d  = '0;
          ffexp_d  = '0;
          ffmeas_d = '0;
          if (num_tests == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            passed_d = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            svalid_d = 1'b1;
            sdata_d  = stim_mem[IDX_ZERO];
          end
        end
      end

      S_ISSUE: begin
        if (stim_ready) begin
          svalid_d = 1'b0;
          tocnt_d  = '0;
          state_d  = S_WAIT_RES;
        end
      end

      S_WAIT_RES: begin
        if (res_valid) begin
          meas_d  = res_data;
          tmo_d   = 1'b0;
          state_d = S_CHECK;
        end else if (tocnt_q == TO_LAST) begin
          meas_d  = '0;
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          tocnt_d = tocnt_q + TO_ONE;
        end
      end

      S_CHECK: begin
        tcnt_d = tcnt_q + CNT_ONE;
        if (vec_fail) begin
          fcnt_d = fcnt_q + CNT_ONE;
          if (!failed_q) begin
            ffidx_d  = idx_q;
            ffexp_d  = exp_mem[idx_q];
            ffmeas_d = meas_q;
            failed_d = 1'b1;
          end
        end
        // The next stimulus word is fetched here so it is registered on entry to ISSUE.
        if (last_vec || (STOP_ON_FAIL && vec_fail)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          passed_d = !vec_fail && (fcnt_q == '0);
        end else begin
          idx_d    = idx_q + IDX_ONE;
          state_d  = S_ISSUE;
          svalid_d = 1'b1;
          sdata_d  = stim_mem[idx_q + IDX_ONE];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ntests_q <= '0;
      tcnt_q   <= '0;
      fcnt_q   <= '0;
      tocnt_q  <= '0;
      meas_q   <= '0;
      tmo_q    <= 1'b0;
      svalid_q <= 1'b0;
      sdata_q  <= '0;
      done_q   <= 1'b0;
      passed_q <= 1'b0;
      failed_q <= 1'b0;
      ffidx_q  <= '0;
      ffexp_q  <= '0;
      ffmeas_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ntests_q <= ntests_d;
      tcnt_q   <= tcnt_d;
      fcnt_q   <= fcnt_d;
      tocnt_q  <= tocnt_d;
      meas_q   <= meas_d;
      tmo_q    <= tmo_d;
      svalid_q <= svalid_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
      passed_q <= passed_d;
      failed_q <= failed_d;
      ffidx_q  <= ffidx_d;
      ffexp_q  <= ffexp_d;
      ffmeas_q <= ffmeas_d;
    end
  end

  assign stim_valid      = svalid_q;
  assign stim_data       = sdata_q;
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT_RES) || (state_q == S_CHECK);
  assign done            = done_q;
  assign test_passed     = passed_q;
  assign test_failed     = failed_q;
  assign test_count      = tcnt_q;
  assign fail_count      = fcnt_q;
  assign first_fail_idx  = ffidx_q;
  assign first_fail_exp  = ffexp_q;
  assign first_fail_meas = ffmeas_q;

endmodule

// File: doc/dsp_vector_source.md
Name: dsp_vector_source

Overview:
- Synthesizable stimulus/response engine that drives a DSP datapath under test from a preloaded table of {stimulus, expected} pairs.
- Compares each returned result against its expected value, counts tests, passes and failures, and raises sticky pass/fail flags at the end of a run.
- Sits between a host/load port and any DSP block with a valid/ready input and a valid-only result output.
- Used for on-board self-test and as the hardware-side counterpart of the bench reporting tasks.

Parameters:
- DATA_WIDTH, 32, width of stimulus, expected and result words.
- ADDR_WIDTH, 4, table index width; table depth is 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for a result before declaring a timeout failure.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_we  in  1  table write strobe; ignored unless the FSM is in IDLE.
- ld_addr  in  ADDR_WIDTH  table write index.
- ld_stim  in  DATA_WIDTH  stimulus word to store.
- ld_exp  in  DATA_WIDTH  expected word to store.
- num_tests  in  ADDR_WIDTH+1  number of vectors to run, 0..2**ADDR_WIDTH; sampled on start.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- stim_valid  out  1  stimulus valid to the DUT.
- stim_ready  in  1  DUT accepts the stimulus.
- stim_data  out  DATA_WIDTH  stimulus word.
- res_valid  in  1  DUT result valid (single-cycle, no backpressure).
- res_data  in  DATA_WIDTH  DUT result word.
- busy  out  1  run in progress.
- done  out  1  sticky; run complete.
- test_passed  out  1  sticky; done with zero failures.
- test_failed  out  1  sticky; at least one mismatch or timeout.
- test_count  out  ADDR_WIDTH+1  vectors completed.
- fail_count  out  ADDR_WIDTH+1  mismatches plus timeouts.
- first_fail_idx  out  ADDR_WIDTH  index of the first failing vector.
- first_fail_exp  out  DATA_WIDTH  expected value at the first failure.
- first_fail_meas  out  DATA_WIDTH  measured value at the first failure (0 on timeout).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; table contents not reset.
- FSM states: IDLE, ISSUE, WAIT_RES, CHECK, DONE.
- IDLE:
  - ld_we writes the table in the same cycle.
  - start → clear counters, flags and first_fail_*; latch num_tests.
  - If num_tests==0, go directly to DONE with test_passed=1. Otherwise go to ISSUE with idx=0.
- ISSUE:
  - stim_valid=1 and stim_data=table[idx], registered outputs.
  - stim_data is held stable until stim_ready is seen; stim_valid is not dropped before acceptance.
  - Handshake (stim_valid & stim_ready) → WAIT_RES; clear the timeout counter.
- WAIT_RES:
  - res_valid → capture res_data → CHECK.
  - Timeout counter reaches TIMEOUT_CYCLES-1 → CHECK with a timeout flag and measured=0.
  - A res_valid arriving in ISSUE, CHECK, IDLE or DONE is ignored.
- CHECK (one cycle):
  - Pass condition: measured==expected and no timeout.
  - Otherwise increment fail_count. On the first failure only, record first_fail_*, then set test_failed.
  - Always increment test_count.
  - If test_count+1==num_tests → DONE; else idx+1 → ISSUE.
- DONE:
  - done=1; test_passed = (fail_count==0).
  - Hold all results until start or reset.
  - start from DONE behaves as from IDLE; ld_we is ignored in DONE.
- busy=1 in ISSUE, WAIT_RES and CHECK.
- Latency per vector: handshake + DUT latency + 2 cycles (capture and CHECK).
- Counters do not overflow, since num_tests ≤ 2**ADDR_WIDTH and the counters are ADDR_WIDTH+1 wide.
- start while busy is ignored.
- rst_n asserted mid-run aborts immediately to the reset state.

Optional Feature:
- Macro: DSP_VECTOR_SOURCE_STOP_ON_FAIL_EN.
- Defined: the first failure in CHECK goes directly to DONE with test_failed=1. test_count includes the failing vector; the remaining vectors are not issued.
- Undefined: the run always completes all num_tests vectors.

Test Plan:
- Load 4 vectors with exp=stim+1; DUT adds 1 with 3-cycle latency; num_tests=4 → done=1, test_passed=1, test_count=4, fail_count=0.
- As above but table[2].exp=0xDEADBEEF, DUT returns 0x00000103 → test_failed=1, fail_count=1, first_fail_idx=2, first_fail_exp=0xDEADBEEF, first_fail_meas=0x00000103, test_count=4 (macro off) or 3 (macro on).
- DUT never asserts res_valid on vector 1, TIMEOUT_CYCLES=16 → timeout after 16 cycles; first_fail_idx=1, first_fail_meas=0; run continues to vector 2 (macro off).
- stim_ready held low 10 cycles → stim_valid stays 1 and stim_data is unchanged throughout; exactly one vector is consumed on acceptance.
- num_tests=0 with start → DONE on the next cycle with test_passed=1 and test_count=0. num_tests=16 (full table) → test_count=16, no wrap.
- rst_n pulsed low during WAIT_RES of vector 2 → all outputs 0 asynchronously and the FSM returns to IDLE. A second start re-runs from idx 0 with the table intact.
